// File: rtl/instr_decode_ctrl.sv
// Four-cycle instruction decode/control sequencer: captures a 16-bit instruction,
// decodes it into registered ALU controls, then updates the PSR and retires it in WB.
module instr_decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_opcode,
  output logic [3:0]  rsrc,
  output logic [3:0]  rdest,
  output logic [15:0] imm,
  output logic        imm_sel,
  output logic        cin,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        reg_we,
  output logic        done,
  output logic        illegal,
  output logic [1:0]  fsm_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, so instr_valid is ignored while an instruction is in flight.
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [15:0] instr_q;
  logic [3:0]  f_op, f_ext, f_amt;
  logic [7:0]  dec_op;
  logic [15:0] dec_imm;
  logic        dec_sel, dec_ill, dec_psr, dec_wr;
  logic        ill_q, psr_en_q, wr_q;

  function automatic logic is_alu(input logic [3:0] c);
    return c inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
  endfunction

  // AND, OR, XOR and MOV leave the flags alone
  function automatic logic keeps_psr(input logic [3:0] c);
    return c inside {4'h1, 4'h2, 4'h3, 4'hD};
  endfunction

  assign f_op  = instr_q[15:12];
  assign f_ext = instr_q[7:4];
  assign f_amt = instr_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dec_op  = 8'h00;
    dec_imm = 16'h0000;
    dec_sel = 1'b0;
    dec_ill = 1'b1;
    dec_psr = 1'b0;
    dec_wr  = 1'b0;
    if (f_op == 4'h0) begin
      if (is_alu(f_ext)) begin
        dec_op  = {4'h0, f_ext};
        dec_ill = 1'b0;
        dec_psr = !keeps_psr(f_ext);
        dec_wr  = (f_ext != 4'hB);
      end
    end else if (f_op == 4'h8) begin
      dec_ill = 1'b0;
      dec_psr = 1'b1;
      dec_wr  = 1'b1;
      unique casez (f_ext)
        4'b1000: dec_op = 8'h88;
        4'b1111: dec_op = 8'h8F;
        4'b000?: begin
          dec_op  = 8'h88;
          dec_sel = 1'b1;
          dec_imm = f_ext[0] ? (16'd0 - {12'd0, f_amt}) : {12'd0, f_amt};
        end
        4'b001?: begin
          dec_op  = 8'h8F;
          dec_sel = 1'b1;
          dec_imm = {12'd0, f_amt};
        end
        default: begin
          dec_ill = 1'b1;
          dec_psr = 1'b0;
          dec_wr  = 1'b0;
        end
      endcase
    end else if (is_alu(f_op)) begin
      dec_op  = {4'h0, f_op};
      dec_sel = 1'b1;
      dec_ill = 1'b0;
      dec_psr = !keeps_psr(f_op);
      dec_wr  = (f_op != 4'hB);
      // logical ops and ADDU take the byte unsigned; arithmetic/MOV sign-extend
      if (f_op inside {4'h1, 4'h2, 4'h3, 4'h6}) dec_imm = {8'h00, instr_q[7:0]};
      else                                     dec_imm = {{8{instr_q[7]}}, instr_q[7:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= 16'h0000;
      alu_opcode <= 8'h00;
      rsrc       <= 4'h0;
      rdest      <= 4'h0;
      imm        <= 16'h0000;
      imm_sel    <= 1'b0;
      ill_q      <= 1'b0;
      psr_en_q   <= 1'b0;
      wr_q       <= 1'b0;
      psr        <= 5'b00000;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == DECODE) begin
        alu_opcode <= dec_op;
        rsrc       <= instr_q[3:0];
        rdest      <= instr_q[11:8];
        imm        <= dec_imm;
        imm_sel    <= dec_sel;
        ill_q      <= dec_ill;
        psr_en_q   <= dec_psr;
        wr_q       <= dec_wr;
      end
      if (state == EXEC && psr_en_q) psr <= alu_flags;
    end
  end

  assign instr_ready = (state == IDLE);
  assign reg_we      = (state == WB) && wr_q;
  assign done        = (state == WB);
  assign illegal     = (state == WB) && ill_q;
  assign cin         = psr[0];
  assign fsm_state   = state;

endmodule
